riscv_exc_ctrl_unit: RTL and testbench

- Exception/interrupt arbitration stage between the ID-stage exception sources and the core controller, feeding the CSR block.
- Registers level-sensitive IRQ lines, prioritises synchronous exceptions over interrupts, and holds one request to the controller until it is accepted.
- On acceptance, pulses the cause-save strobe into the CSR block and presents the 6-bit mcause value.
- Interrupts are gated by the mstatus IE bit supplied by the CSR block.

---
 rtl/riscv_exc_ctrl_unit_pkg.sv | 45 ++++
 rtl/riscv_irq_prio_enc.sv | 20 ++
 rtl/riscv_exc_ctrl_unit.sv | 142 ++++++++++++++
 tb/tb_riscv_exc_ctrl_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_exc_ctrl_unit_pkg.sv
// Trap cause codes, arbitration FSM states and the sync-exception priority
// function shared by the exception control unit.
package riscv_exc_ctrl_unit_pkg;

    localparam logic [5:0] EXC_CAUSE_ILLEGAL     = 6'h02;
    localparam logic [5:0] EXC_CAUSE_BREAKPOINT  = 6'h03;
    localparam logic [5:0] EXC_CAUSE_ECALL       = 6'h0B;
    localparam logic [5:0] EXC_CAUSE_LOAD_FAULT  = 6'h05;
    localparam logic [5:0] EXC_CAUSE_STORE_FAULT = 6'h07;
    localparam logic [5:0] EXC_CAUSE_TAG_VIOL    = 6'h1A;
    localparam logic [5:0] EXC_CAUSE_IRQ_FLAG    = 6'h20;

    typedef enum logic [1:0] {
        EXC_IDLE,
        EXC_REQ,
        EXC_COMMIT,
        EXC_WAIT
    } exc_fsm_e;

    // Field order matches arbitration priority, highest first.
    typedef struct packed {
        logic tag;
        logic illegal;
        logic ebrk;
        logic ecall;
        logic load_err;
        logic store_err;
    } sync_src_t;

    function automatic logic [5:0] sync_cause(input sync_src_t src);
        logic [5:0] cause;
        cause = EXC_CAUSE_STORE_FAULT;
        if (src.tag)           cause = EXC_CAUSE_TAG_VIOL;
        else if (src.illegal)  cause = EXC_CAUSE_ILLEGAL;
        else if (src.ebrk)     cause = EXC_CAUSE_BREAKPOINT;
        else if (src.ecall)    cause = EXC_CAUSE_ECALL;
        else if (src.load_err) cause = EXC_CAUSE_LOAD_FAULT;
        return cause;
    endfunction

    function automatic logic [5:0] irq_cause(input logic [4:0] id);
        return EXC_CAUSE_IRQ_FLAG | {1'b0, id};
    endfunction

endpackage

// File: rtl/riscv_irq_prio_enc.sv
// Highest-index-wins priority encoder over the registered interrupt lines.
module riscv_irq_prio_enc #(
    parameter int unsigned N_IRQ = 32,
    parameter int unsigned ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic [N_IRQ-1:0] irq_i,
    output logic             valid_o,
    output logic [ID_W-1:0]  id_o
);

    always_comb begin
        valid_o = |irq_i;
        id_o    = '0;
        // Ascending scan: the last set bit seen is the highest index.
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (irq_i[i]) id_o = ID_W'(i);
        end
    end

endmodule

// File: rtl/riscv_exc_ctrl_unit.sv
// Exception/interrupt arbitration between ID-stage sources and the controller.
// Optional DIFT tag-violation trap source enabled by defining DIFT_TAG_TRAP_EN.
module riscv_exc_ctrl_unit
    import riscv_exc_ctrl_unit_pkg::*;
#(
    parameter int unsigned N_IRQ    = 32,
    parameter int unsigned IRQ_ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_IRQ-1:0]    irq_i,
    input  logic [N_IRQ-1:0]    irq_mask_i,
    input  logic                irq_enable_i,
    input  logic                illegal_insn_i,
    input  logic                ebrk_insn_i,
    input  logic                ecall_insn_i,
    input  logic                lsu_load_err_i,
    input  logic                lsu_store_err_i,
`ifdef DIFT_TAG_TRAP_EN
    input  logic                tag_violation_i,
`endif
    output logic                req_o,
    input  logic                ack_i,
    output logic                is_irq_o,
    output logic [IRQ_ID_W-1:0] irq_id_o,
    output logic [5:0]          cause_o,
    output logic                save_cause_o
);

    exc_fsm_e              state_q, state_d;
    logic [5:0]            cause_q, cause_d;
    logic                  is_irq_q, is_irq_d;
    logic [IRQ_ID_W-1:0]   irq_id_q, irq_id_d;
    logic [N_IRQ-1:0]      irq_q;

    logic                  irq_valid;
    logic [IRQ_ID_W-1:0]   irq_id;
    logic                  irq_cand;
    logic                  latched_irq_live;
    sync_src_t             sync_src;
    logic                  sync_valid;
    logic [5:0]            sync_code;
    logic                  tag_upgrade;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= '0;
        else        irq_q <= irq_i & irq_mask_i;
    end

    riscv_irq_prio_enc #(
        .N_IRQ (N_IRQ),
        .ID_W  (IRQ_ID_W)
    ) u_irq_prio_enc (
        .irq_i   (irq_q),
        .valid_o (irq_valid),
        .id_o    (irq_id)
    );

`ifdef DIFT_TAG_TRAP_EN
    assign sync_src.tag = tag_violation_i;
`else
    assign sync_src.tag = 1'b0;
`endif
    assign sync_src.illegal   = illegal_insn_i;
    assign sync_src.ebrk      = ebrk_insn_i;
    assign sync_src.ecall     = ecall_insn_i;
    assign sync_src.load_err  = lsu_load_err_i;
    assign sync_src.store_err = lsu_store_err_i;

    assign sync_valid = |sync_src;
    assign sync_code  = sync_cause(sync_src);
    assign irq_cand   = irq_valid & irq_enable_i;

    // The latched interrupt stays valid only while its own registered line is high.
    assign latched_irq_live = |(irq_q & (N_IRQ'(1) << irq_id_q));

    // A tag violation may displace any other latched sync cause.
    assign tag_upgrade = sync_src.tag && !is_irq_q && (cause_q != EXC_CAUSE_TAG_VIOL);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        is_irq_d = is_irq_q;
        irq_id_d = irq_id_q;

        unique case (state_q)
            EXC_IDLE: begin
                if (sync_valid) begin
                    cause_d  = sync_code;
                    is_irq_d = 1'b0;
                    state_d  = EXC_REQ;
                end else if (irq_cand) begin
                    cause_d  = irq_cause(5'(irq_id));
                    is_irq_d = 1'b1;
                    irq_id_d = irq_id;
                    state_d  = EXC_REQ;
                end
            end
            EXC_REQ: begin
                if (ack_i) begin
                    state_d = EXC_COMMIT;
                end else if (is_irq_q && sync_valid) begin
                    // The displaced interrupt is level-sensitive and re-arbitrates later.
                    cause_d  = sync_code;
                    is_irq_d = 1'b0;
                end else if (is_irq_q && (!irq_enable_i || !latched_irq_live)) begin
                    state_d = EXC_IDLE;
                end else if (tag_upgrade) begin
                    cause_d = EXC_CAUSE_TAG_VIOL;
                end
            end
            EXC_COMMIT: state_d = EXC_WAIT;
            EXC_WAIT:   state_d = EXC_IDLE;
            default:    state_d = EXC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EXC_IDLE;
            cause_q  <= '0;
            is_irq_q <= 1'b0;
            irq_id_q <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            is_irq_q <= is_irq_d;
            irq_id_q <= irq_id_d;
        end
    end

    // Decoded straight from the state register so reset clears them immediately.
    assign req_o        = (state_q == EXC_REQ);
    assign save_cause_o = (state_q == EXC_COMMIT);
    assign cause_o      = cause_q;
    assign is_irq_o     = is_irq_q;
    assign irq_id_o     = irq_id_q;

endmodule

// File: tb/tb_riscv_exc_ctrl_unit.sv
// Directed bench for riscv_exc_ctrl_unit with a save-strobe scoreboard.
module tb_riscv_exc_ctrl_unit;

    typedef struct {
        logic [5:0] cause;
        logic       is_irq;
        logic [4:0] id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] irq_i;
    logic [31:0] irq_mask_i;
    logic        irq_enable_i;
    logic        illegal_insn_i;
    logic        ebrk_insn_i;
    logic        ecall_insn_i;
    logic        lsu_load_err_i;
    logic        lsu_store_err_i;
    logic        tag_violation_i;
    logic        req_o;
    logic        ack_i;
    logic        is_irq_o;
    logic [4:0]  irq_id_o;
    logic [5:0]  cause_o;
    logic        save_cause_o;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    riscv_exc_ctrl_unit #(.N_IRQ(32), .IRQ_ID_W(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .irq_i           (irq_i),
        .irq_mask_i      (irq_mask_i),
        .irq_enable_i    (irq_enable_i),
        .illegal_insn_i  (illegal_insn_i),
        .ebrk_insn_i     (ebrk_insn_i),
        .ecall_insn_i    (ecall_insn_i),
        .lsu_load_err_i  (lsu_load_err_i),
        .lsu_store_err_i (lsu_store_err_i),
`ifdef DIFT_TAG_TRAP_EN
        .tag_violation_i (tag_violation_i),
`endif
        .req_o           (req_o),
        .ack_i           (ack_i),
        .is_irq_o        (is_irq_o),
        .irq_id_o        (irq_id_o),
        .cause_o         (cause_o),
        .save_cause_o    (save_cause_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] cause, input logic is_irq, input logic [4:0] id);
        exp_t e;
        e.cause  = cause;
        e.is_irq = is_irq;
        e.id     = id;
        sb_q.push_back(e);
    endtask

    task automatic check_req(input string name, input logic [5:0] cause, input logic is_irq,
                             input logic [4:0] id);
        check({name, "_req"}, 32'(req_o), 32'd1);
        check({name, "_cause"}, 32'(cause_o), 32'(cause));
        check({name, "_is_irq"}, 32'(is_irq_o), 32'(is_irq));
        if (is_irq) check({name, "_id"}, 32'(irq_id_o), 32'(id));
    endtask

    // Accept the pending request and walk through COMMIT and WAIT back to IDLE.
    task automatic do_commit(input string name);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        check({name, "_commit_req"}, 32'(req_o), 32'd0);
        check({name, "_commit_save"}, 32'(save_cause_o), 32'd1);
        tick();
        check({name, "_wait_req"}, 32'(req_o), 32'd0);
        check({name, "_wait_save"}, 32'(save_cause_o), 32'd0);
        tick();
    endtask

    // Monitor: every save strobe must match the next expected trap.
    always @(negedge clk) begin
        if (rst_n && save_cause_o) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_save", 32'(cause_o), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_cause", 32'(cause_o), 32'(e.cause));
                check("sb_is_irq", 32'(is_irq_o), 32'(e.is_irq));
                if (e.is_irq) check("sb_id", 32'(irq_id_o), 32'(e.id));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; irq_i = '0; irq_mask_i = '1; irq_enable_i = 1'b1; ack_i = 1'b0;
        illegal_insn_i = 1'b0; ebrk_insn_i = 1'b0; ecall_insn_i = 1'b0;
        lsu_load_err_i = 1'b0; lsu_store_err_i = 1'b0; tag_violation_i = 1'b0;
        tick(); tick();
        check("rst_req", 32'(req_o), 32'd0);
        check("rst_save", 32'(save_cause_o), 32'd0);
        check("rst_cause", 32'(cause_o), 32'd0);
        check("rst_is_irq", 32'(is_irq_o), 32'd0);
        check("rst_id", 32'(irq_id_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // Interrupt 5: request two cycles after the line rises.
        irq_i[5] = 1'b1;
        tick();
        check("irq5_lat1_req", 32'(req_o), 32'd0);
        tick();
        check_req("irq5", 6'h25, 1'b1, 5'd5);
        push(6'h25, 1'b1, 5'd5);
        irq_i = '0;
        do_commit("irq5");
        tick();
        check("irq5_idle_req", 32'(req_o), 32'd0);

        // Highest index wins; the lower one follows after the winner clears.
        irq_i[3] = 1'b1; irq_i[17] = 1'b1;
        tick(); tick();
        check_req("irq17", 6'h31, 1'b1, 5'd17);
        push(6'h31, 1'b1, 5'd17);
        irq_i[17] = 1'b0;
        do_commit("irq17");
        tick();
        check_req("irq3", 6'h23, 1'b1, 5'd3);
        push(6'h23, 1'b1, 5'd3);
        irq_i = '0;
        do_commit("irq3");
        tick();

        // Sync exception displaces a pending interrupt, which re-requests later.
        irq_i[9] = 1'b1;
        tick(); tick();
        check_req("irq9", 6'h29, 1'b1, 5'd9);
        illegal_insn_i = 1'b1;
        tick();
        illegal_insn_i = 1'b0;
        check_req("ill_over_irq", 6'h02, 1'b0, 5'd0);
        tick();
        check_req("ill_hold", 6'h02, 1'b0, 5'd0);
        push(6'h02, 1'b0, 5'd0);
        do_commit("ill");
        tick();
        check_req("irq9_again", 6'h29, 1'b1, 5'd9);
        push(6'h29, 1'b1, 5'd9);
        irq_i = '0;
        do_commit("irq9b");
        tick();

        // Interrupt withdrawn when IE drops; ecall still traps with IE low.
        irq_i[4] = 1'b1;
        tick(); tick();
        check_req("irq4", 6'h24, 1'b1, 5'd4);
        irq_enable_i = 1'b0;
        tick();
        check("irq4_withdraw_req", 32'(req_o), 32'd0);
        check("irq4_withdraw_save", 32'(save_cause_o), 32'd0);
        tick();
        check("irq4_ie_off_req", 32'(req_o), 32'd0);
        ecall_insn_i = 1'b1;
        tick();
        ecall_insn_i = 1'b0;
        check_req("ecall", 6'h0B, 1'b0, 5'd0);
        push(6'h0B, 1'b0, 5'd0);
        do_commit("ecall");
        irq_i = '0;
        tick(); tick();
        irq_enable_i = 1'b1;

        // Interrupt withdrawn when its line drops before acknowledgement.
        irq_i[7] = 1'b1;
        tick(); tick();
        check_req("irq7", 6'h27, 1'b1, 5'd7);
        irq_i = '0;
        tick();
        check("irq7_still_req", 32'(req_o), 32'd1);
        tick();
        check("irq7_withdraw_req", 32'(req_o), 32'd0);
        tick();

        // ack outside REQ is ignored.
        ack_i = 1'b1;
        tick();
        check("stray_ack_req", 32'(req_o), 32'd0);
        check("stray_ack_save", 32'(save_cause_o), 32'd0);
        ack_i = 1'b0;
        tick();

        // Sync sources are ignored during COMMIT and WAIT.
        lsu_store_err_i = 1'b1;
        tick();
        lsu_store_err_i = 1'b0;
        check_req("store", 6'h07, 1'b0, 5'd0);
        push(6'h07, 1'b0, 5'd0);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        check("store_commit_save", 32'(save_cause_o), 32'd1);
        illegal_insn_i = 1'b1;
        tick();
        check("ign_wait_req", 32'(req_o), 32'd0);
        tick();
        illegal_insn_i = 1'b0;
        check("ign_idle_req", 32'(req_o), 32'd0);
        tick();
        check("ign_after_req", 32'(req_o), 32'd0);

        // ebreak beats load error; reset during COMMIT kills the strobe.
        ebrk_insn_i = 1'b1; lsu_load_err_i = 1'b1;
        tick();
        ebrk_insn_i = 1'b0; lsu_load_err_i = 1'b0;
        check_req("ebrk", 6'h03, 1'b0, 5'd0);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        check("ebrk_commit_save", 32'(save_cause_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_save", 32'(save_cause_o), 32'd0);
        check("midrst_req", 32'(req_o), 32'd0);
        check("midrst_cause", 32'(cause_o), 32'd0);
        check("midrst_is_irq", 32'(is_irq_o), 32'd0);
        check("midrst_id", 32'(irq_id_o), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("postrst_req", 32'(req_o), 32'd0);
        check("postrst_save", 32'(save_cause_o), 32'd0);

`ifdef DIFT_TAG_TRAP_EN
        tag_violation_i = 1'b1; illegal_insn_i = 1'b1;
        tick();
        tag_violation_i = 1'b0; illegal_insn_i = 1'b0;
        check_req("tag_vs_ill", 6'h1A, 1'b0, 5'd0);
        push(6'h1A, 1'b0, 5'd0);
        do_commit("tag1");
        tick();
        ecall_insn_i = 1'b1;
        tick();
        ecall_insn_i = 1'b0;
        check_req("ecall_pre_tag", 6'h0B, 1'b0, 5'd0);
        tag_violation_i = 1'b1;
        tick();
        tag_violation_i = 1'b0;
        check_req("tag_upgrade", 6'h1A, 1'b0, 5'd0);
        push(6'h1A, 1'b0, 5'd0);
        do_commit("tag2");
        tick();
`endif

        tick(); tick();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
